// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage Y86-64 pipeline.
//
// Produces per-stage stall/bubble controls and the condition-code write
// enable from the stage-register contents. The controls are combinational.
// A run-state machine handles a debugger pause/drain handshake and a sticky
// halt on exception. Two saturating performance counters track cycles
// and retired instructions.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   D/E/M/W_icode               stage-register icodes (nop = 4'h1)
//   E_dstM                      execute-stage memory destination (4'hF = none)
//   d_srcA, d_srcB              decode source registers
//   e_cnd                       execute condition result
//   m_stat, W_stat              one-hot status, AOK=1000 HLT=0100 ADR=0010 INS=0001
//   halt_req, resume            single-cycle pause / resume pulses
//   F_stall .. SetCC            stage controls
//   paused, halted              run-state indicators
//   final_stat                  W_stat captured when HALTED is entered
//   cycle_cnt, retire_cnt       saturating performance counters
module pipe_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_cnd,
  input  logic [0:3]       m_stat,
  input  logic [0:3]       W_stat,
  input  logic             halt_req,
  input  logic             resume,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             SetCC,
  output logic             paused,
  output logic             halted,
  output logic [0:3]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [0:3] S_AOK    = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PAUSED,
    ST_HALTED
  } state_t;

  state_t state;

  logic lu, rt, mp, exc, w_exc, g;
  logic f_stall, d_stall, d_bub, e_bub, m_bub, w_stl, set_cc;
  logic cnt_en;

  assign lu    = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE) &&
                 (E_dstM == d_srcA || E_dstM == d_srcB);
  assign rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp    = (E_icode == I_JXX) && !e_cnd;
  assign w_exc = (W_stat != S_AOK);
  assign exc   = (m_stat != S_AOK) || w_exc;
  // While draining, fetch only freezes once no control transfer is in flight.
  assign g     = !(mp || rt || E_icode == I_JXX);

  always_comb begin
    f_stall = lu | rt;
    d_stall = lu;
    d_bub   = mp | (rt & ~lu);
    e_bub   = mp | lu;
    m_bub   = exc;
    w_stl   = w_exc;
    set_cc  = (E_icode == I_OPQ) && !exc;
    unique case (state)
      ST_DRAIN: begin
        if (g) begin
          f_stall = 1'b1;
          d_stall = 1'b0;
          d_bub   = 1'b1;
          e_bub   = lu;
        end
      end
      ST_PAUSED: begin
        f_stall = 1'b1;
        d_stall = 1'b0;
        d_bub   = 1'b1;
        e_bub   = 1'b1;
        m_bub   = 1'b1;
        w_stl   = 1'b0;
        set_cc  = 1'b0;
      end
      ST_HALTED: begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        d_bub   = 1'b0;
        e_bub   = 1'b1;
        m_bub   = 1'b1;
        w_stl   = 1'b1;
        set_cc  = 1'b0;
      end
      default: ;
    endcase
  end

  assign F_stall  = f_stall;
  assign D_stall  = d_stall;
  // Stall wins over bubble on the decode register.
  assign D_bubble = d_bub & ~d_stall;
  assign E_bubble = e_bub;
  assign M_bubble = m_bub;
  assign W_stall  = w_stl;
  assign SetCC    = set_cc;

  assign paused = (state == ST_PAUSED);
  assign halted = (state == ST_HALTED);
  assign cnt_en = (state == ST_RUN) || (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      final_stat <= S_AOK;
    end else begin
      if (cnt_en && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + CNT_ONE;
      if (cnt_en && !w_exc && W_icode != I_NOP && retire_cnt != '1)
        retire_cnt <= retire_cnt + CNT_ONE;

      // A writeback exception overrides every other transition and sticks.
      if (w_exc) begin
        if (state != ST_HALTED)
          final_stat <= W_stat;
        state <= ST_HALTED;
      end else begin
        unique case (state)
          ST_RUN:    if (halt_req) state <= ST_DRAIN;
          ST_DRAIN:  if (E_icode == I_NOP && M_icode == I_NOP && W_icode == I_NOP && D_bubble)
                       state <= ST_PAUSED;
          ST_PAUSED: if (resume) state <= ST_RUN;
          default:   ;
        endcase
      end
    end
  end

endmodule
